// File: rtl/popcount_pkg.sv
// Shared types and constants for the popcount accelerator.
package popcount_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, COUNT, STORE, DONE} state_t;

  localparam int WORD_W = 32;
  localparam int WCNT_W = 6;

  // Chunk width must divide the word evenly and be a power of two.
  function automatic bit isLegalChunk(input int bits);
    case (bits)
      1, 2, 4, 8, 16, 32: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/popcount_engine_popcnt_chunk.sv
// Combinational population count of one CHUNK_BITS-wide slice.
module popcnt_chunk #(
  parameter int CHUNK_BITS = 4,
  parameter int PC_W       = $clog2(CHUNK_BITS + 1)
) (
  input  logic [CHUNK_BITS-1:0] i_bits,
  output logic [PC_W-1:0]       o_count
);

  always_comb begin
    o_count = '0;
    for (int k = 0; k < CHUNK_BITS; k++) begin
      o_count = o_count + PC_W'(i_bits[k]);
    end
  end

endmodule

// File: rtl/popcount_engine.sv
// Memory-mastering bit-count engine: per-word popcounts written to a result
// array, serial CHUNK_BITS per cycle, with a running grand total.
module popcount_engine
  import popcount_pkg::*;
#(
  parameter int CHUNK_BITS = 4,
  parameter int CNT_W      = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [CNT_W-1:0]    num_words,
  output logic                busy,
  output logic                done,
  output logic [CNT_W+4:0]    total,
  output logic                mem_we,
  output logic [31:0]         mem_a,
  output logic [31:0]         mem_wd,
  input  logic [31:0]         mem_rd
);

  localparam int NCHUNK = WORD_W / CHUNK_BITS;
  localparam int CC_W   = $clog2(NCHUNK) + 1;
  localparam int PC_W   = $clog2(CHUNK_BITS + 1);
  localparam int TOT_W  = CNT_W + 5;
  localparam int AW     = WORD_W - 2;

  if (!isLegalChunk(CHUNK_BITS)) begin : gBadChunk
    $error("popcount_engine: CHUNK_BITS must be one of 1, 2, 4, 8, 16, 32");
  end

  state_t             r_state;
  logic [AW-1:0]      r_srcW;
  logic [AW-1:0]      r_dstW;
  logic [CNT_W-1:0]   r_numWords;
  logic [CNT_W-1:0]   r_idx;
  logic [WORD_W-1:0]  r_shift;
  logic [WCNT_W-1:0]  r_wordCnt;
  logic [CC_W-1:0]    r_chunkIdx;
  logic [TOT_W-1:0]   r_total;
  logic               r_busy;
  logic               r_done;
  logic               r_memWe;
  logic [31:0]        r_memA;
  logic [31:0]        r_memWd;

  logic [PC_W-1:0]    w_pop;
  logic [WCNT_W-1:0]  w_nextCnt;
  logic [CNT_W-1:0]   w_idxNext;
  logic [31:0]        w_storeA;
  logic [31:0]        w_nextLoadA;
  logic               w_lastChunk;
  logic               w_unusedAddrBits;

  popcnt_chunk #(
    .CHUNK_BITS (CHUNK_BITS),
    .PC_W       (PC_W)
  ) uChunk (
    .i_bits  (r_shift[CHUNK_BITS-1:0]),
    .o_count (w_pop)
  );

  // Addresses are kept as word addresses so the byte offset is always 00.
  assign w_nextCnt        = r_wordCnt + WCNT_W'(w_pop);
  assign w_idxNext        = r_idx + CNT_W'(1);
  assign w_storeA         = {r_dstW + AW'(r_idx), 2'b00};
  assign w_nextLoadA      = {r_srcW + AW'(w_idxNext), 2'b00};
  assign w_lastChunk      = (r_chunkIdx == CC_W'(NCHUNK - 1));
  assign w_unusedAddrBits = ^{src_addr[1:0], dst_addr[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_srcW     <= '0;
      r_dstW     <= '0;
      r_numWords <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_wordCnt  <= '0;
      r_chunkIdx <= '0;
      r_total    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_memWe    <= 1'b0;
      r_memA     <= '0;
      r_memWd    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_memA  <= '0;
          r_memWe <= 1'b0;
          r_memWd <= '0;
          r_done  <= 1'b0;
          if (start) begin
            r_srcW     <= src_addr[31:2];
            r_dstW     <= dst_addr[31:2];
            r_numWords <= num_words;
            r_total    <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            if (num_words == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= LOAD;
              r_memA  <= {src_addr[31:2], 2'b00};
            end
          end
        end

        LOAD: begin
          r_shift    <= mem_rd;
          r_wordCnt  <= '0;
          r_chunkIdx <= '0;
          r_state    <= COUNT;
        end

        COUNT: begin
          r_wordCnt  <= w_nextCnt;
          r_shift    <= r_shift >> CHUNK_BITS;
          r_chunkIdx <= r_chunkIdx + CC_W'(1);
          if (w_lastChunk) begin
            r_state <= STORE;
            r_memWe <= 1'b1;
            r_memA  <= w_storeA;
            r_memWd <= 32'(w_nextCnt);
          end
        end

        STORE: begin
          r_memWe <= 1'b0;
          r_memWd <= '0;
          r_total <= r_total + TOT_W'(r_wordCnt);
          r_idx   <= w_idxNext;
          if (w_idxNext == r_numWords) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_memA  <= '0;
          end else begin
            r_state <= LOAD;
            r_memA  <= w_nextLoadA;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_memA  <= '0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // A STORE that coincides with reset must never reach the memory.
  assign mem_we = r_memWe & ~reset;
  assign mem_wd = mem_we ? r_memWd : '0;
  assign mem_a  = r_memA;
  assign busy   = r_busy;
  assign done   = r_done;
  assign total  = r_total;

endmodule

// File: tb/tb_popcount_engine.sv
// Bench for popcount_engine: four instances (CHUNK_BITS 4, 1, 8, 32), each
// with its own 64-word memory, driven by a shared job table.
module tb_popcount_engine;

  localparam int NDUT   = 4;
  localparam int CNT_W  = 7;
  localparam int TOT_W  = CNT_W + 5;
  localparam int BUDGET = 200;
  localparam int CHUNKS [NDUT] = '{4, 1, 8, 32};

  typedef struct {
    logic [31:0]          src;
    logic [31:0]          dst;
    int                   n;
    logic [0:4][31:0]     data;
    logic [0:4][5:0]      exp;
    int                   expTotal;
    int                   extraStart;
  } job_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [31:0]       srcAddr;
  logic [31:0]       dstAddr;
  logic [CNT_W-1:0]  numWords;
  logic              busy  [NDUT];
  logic              done  [NDUT];
  logic              we    [NDUT];
  logic [TOT_W-1:0]  total [NDUT];
  logic [31:0]       a     [NDUT];
  logic [31:0]       wd    [NDUT];
  logic [31:0]       rd    [NDUT];
  logic [31:0]       ram   [NDUT][64];

  int                compared   = 0;
  int                mismatched = 0;
  int                doneCyc    [NDUT];
  int                donePulses [NDUT];
  int                busyCycles [NDUT];
  int                wrCount    [NDUT];
  bit                protoErr   [NDUT];
  logic              busySnap   [NDUT];
  logic [TOT_W-1:0]  totalSnap  [NDUT];
  job_t              jobs [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    assign rd[g] = ram[g][a[g][7:2]];
    popcount_engine #(
      .CHUNK_BITS (CHUNKS[g]),
      .CNT_W      (CNT_W)
    ) uDut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .src_addr  (srcAddr),
      .dst_addr  (dstAddr),
      .num_words (numWords),
      .busy      (busy[g]),
      .done      (done[g]),
      .total     (total[g]),
      .mem_we    (we[g]),
      .mem_a     (a[g]),
      .mem_wd    (wd[g]),
      .mem_rd    (rd[g])
    );
  end

  task automatic checkOutput(input string name, input int k, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s (dut%0d chunk=%0d): got %0d, expected %0d",
               name, k, CHUNKS[k], act, exp);
    end
  endtask

  task automatic presetMemory(input job_t j);
    logic [5:0] w;
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 64; i++) ram[k][i] = 32'h0;
      for (int i = 0; i < j.n; i++) begin
        w = j.src[7:2] + 6'(i);
        ram[k][w] = j.data[i];
      end
    end
  endtask

  // Runs one job for BUDGET cycles; the memory writes are performed here,
  // just before the edge that would commit them.
  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                               input int n, input int extraStart, input int resetCyc);
    @(negedge clk);
    srcAddr  = src;
    dstAddr  = dst;
    numWords = CNT_W'(n);
    start    = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      doneCyc[k]    = -1;
      donePulses[k] = 0;
      busyCycles[k] = 0;
      wrCount[k]    = 0;
      protoErr[k]   = 1'b0;
    end
    @(posedge clk);
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      start = (c == extraStart);
      if (resetCyc > 0) reset = (c == resetCyc);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        if (c == resetCyc + 1) begin
          busySnap[k]  = busy[k];
          totalSnap[k] = total[k];
        end
        if (done[k]) begin
          donePulses[k]++;
          if (doneCyc[k] < 0) doneCyc[k] = c;
        end
        if (busy[k]) busyCycles[k]++;
        if ((!we[k] && wd[k] != 32'h0) || a[k][1:0] != 2'b00) protoErr[k] = 1'b1;
        if (we[k]) begin
          ram[k][a[k][7:2]] = wd[k];
          wrCount[k]++;
        end
      end
    end
  endtask

  task automatic runJob(input job_t j);
    int lat;
    logic [5:0] w;
    presetMemory(j);
    applyStimulus(j.src, j.dst, j.n, j.extraStart, 0);
    for (int k = 0; k < NDUT; k++) begin
      lat = (j.n == 0) ? 1 : j.n * (2 + 32 / CHUNKS[k]) + 1;
      checkOutput("done_cycle",  k, doneCyc[k],    lat);
      checkOutput("done_pulses", k, donePulses[k], 1);
      checkOutput("busy_cycles", k, busyCycles[k], lat);
      checkOutput("write_count", k, wrCount[k],    j.n);
      checkOutput("total",       k, int'(total[k]), j.expTotal);
      checkOutput("protocol",    k, int'(protoErr[k]), 0);
      checkOutput("idle_addr",   k, int'(a[k]),    0);
      for (int i = 0; i < j.n; i++) begin
        w = j.dst[7:2] + 6'(i);
        checkOutput("result_word", k, int'(ram[k][w]), int'(j.exp[i]));
      end
    end
  endtask

  initial begin
    jobs[0] = '{src: 32'h20, dst: 32'hC0, n: 4,
                data: {32'h99999999, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h0},
                exp: {6'd16, 6'd32, 6'd31, 6'd31, 6'd0}, expTotal: 110, extraStart: 0};
    jobs[1] = '{src: 32'h00, dst: 32'hC0, n: 5,
                data: {32'h0, 32'h1, 32'h200, 32'h400000, 32'h80000000},
                exp: {6'd0, 6'd1, 6'd1, 6'd1, 6'd1}, expTotal: 4, extraStart: 0};
    jobs[2] = '{src: 32'h20, dst: 32'hC0, n: 0,
                data: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                exp: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0}, expTotal: 0, extraStart: 0};
    jobs[3] = '{src: 32'h41, dst: 32'h82, n: 2,
                data: {32'h12345678, 32'h0F0F0F0F, 32'h0, 32'h0, 32'h0},
                exp: {6'd13, 6'd16, 6'd0, 6'd0, 6'd0}, expTotal: 29, extraStart: 0};
    jobs[4] = '{src: 32'h4C, dst: 32'h4C, n: 1,
                data: {32'hC0000003, 32'h0, 32'h0, 32'h0, 32'h0},
                exp: {6'd4, 6'd0, 6'd0, 6'd0, 6'd0}, expTotal: 4, extraStart: 3};

    reset    = 1'b1;
    start    = 1'b0;
    srcAddr  = 32'h0;
    dstAddr  = 32'h0;
    numWords = '0;
    for (int k = 0; k < NDUT; k++)
      for (int i = 0; i < 64; i++) ram[k][i] = 32'h0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      checkOutput("reset_busy",  k, int'(busy[k]),  0);
      checkOutput("reset_done",  k, int'(done[k]),  0);
      checkOutput("reset_total", k, int'(total[k]), 0);
      checkOutput("reset_we",    k, int'(we[k]),    0);
      checkOutput("reset_addr",  k, int'(a[k]),     0);
      checkOutput("reset_wd",    k, int'(wd[k]),    0);
    end
    reset = 1'b0;

    for (int j = 0; j < 5; j++) runJob(jobs[j]);

    // Reset lands in cycle 24: word 2 COUNT for chunk 4, word 3 STORE for chunk 8.
    presetMemory(jobs[0]);
    applyStimulus(jobs[0].src, jobs[0].dst, 4, 0, 24);
    reset = 1'b0;
    checkOutput("rst_busy_after",  0, int'(busySnap[0]),  0);
    checkOutput("rst_total_after", 0, int'(totalSnap[0]), 0);
    checkOutput("rst_write_count", 0, wrCount[0],       2);
    checkOutput("rst_word0",       0, int'(ram[0][48]), 16);
    checkOutput("rst_word1",       0, int'(ram[0][49]), 32);
    checkOutput("rst_word2",       0, int'(ram[0][50]), 0);
    checkOutput("rst_done_pulses", 0, donePulses[0],    0);
    checkOutput("rst_write_count", 2, wrCount[2],       3);
    checkOutput("rst_store_supp",  2, int'(ram[2][51]), 0);
    checkOutput("rst_done_pulses", 2, donePulses[2],    0);

    runJob(jobs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
